// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the divide-sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

  // R-type function codes seen by the Divider and HiLo path.
  localparam logic [5:0] FUNCT_DIV  = 6'd26;
  localparam logic [5:0] FUNCT_DIVU = 6'd27;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;

  // Divide sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Function code for a divide of the given signedness.
  function automatic logic [5:0] div_funct(input logic is_signed);
    return is_signed ? FUNCT_DIV : FUNCT_DIVU;
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// EX-stage <-> divide sequencer bundle: EX decode/operand info in, control out.
// Latency: n/a (wires only).
// Backpressure: stall/bubble travel back to the pipeline through this bundle.
//   master (pipeline) drives ex_valid, ex_is_div, ex_signed, ex_is_hilo_rd,
//                     ex_divisor, flush
//   slave (sequencer) drives div_op, div_busy, hilo_we, stall, bubble,
//                     div_zero, stall_cnt
interface muldiv_sched_if #(
  parameter int CNT_W = 16
);

  logic             ex_valid;
  logic             ex_is_div;
  logic             ex_signed;
  logic             ex_is_hilo_rd;
  logic [31:0]      ex_divisor;
  logic             flush;

  logic [5:0]       div_op;
  logic             div_busy;
  logic             hilo_we;
  logic             stall;
  logic             bubble;
  logic             div_zero;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_valid, ex_is_div, ex_signed, ex_is_hilo_rd, ex_divisor, flush,
    input  div_op, div_busy, hilo_we, stall, bubble, div_zero, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_is_div, ex_signed, ex_is_hilo_rd, ex_divisor, flush,
    output div_op, div_busy, hilo_we, stall, bubble, div_zero, stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: +1 per cycle with inc=1, holds at all-ones.
// Latency: count visible the cycle after inc.
// Backpressure: none; inc while saturated is dropped.
//   clk, rst (async active-low clear), inc in; cnt[W-1:0] out
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage sequencer for the multi-cycle Divider and HiLo write.
// Latency: DIV in EX at T -> Divider runs T+1..T+DIV_CYCLES, hilo_we at T+DIV_CYCLES+1.
// Backpressure: stalls front end + bubbles EX/MEM while an EX op needs the busy unit.
//   clk, rst (async active-low) plain ports; all EX info and control outputs
//   travel on bus (muldiv_sched_if.slave).
module muldiv_sched #(
  parameter int DIV_CYCLES = 32,  // legal 2..63 (6-bit down-counter)
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_sched_if.slave bus
);

  import mips_pkg::*;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cnt;
  logic       sign_q;
  logic       div_zero_q;
  logic       go;
  logic       stall_c;
  logic [5:0] div_op_c;
  logic       busy_c;
  logic       we_c;

  // A killed (flushed) EX instruction must neither start a divide nor stall.
  assign go = bus.ex_valid & bus.ex_is_div & ~bus.flush & (state == ST_IDLE);

  // DONE still counts as busy: HiLo only updates at the end of that cycle, so a
  // reader in EX during DONE must wait one more cycle.
  assign stall_c = bus.ex_valid & ~bus.flush & (state != ST_IDLE) &
                   (bus.ex_is_hilo_rd | bus.ex_is_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_op_c  = 6'd0;
    busy_c    = 1'b0;
    we_c      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        div_op_c = div_funct(sign_q);
        busy_c   = 1'b1;
        if (cnt == 6'd1) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        div_op_c  = div_funct(sign_q);
        busy_c    = 1'b1;
        we_c      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latency counter: loaded on start, counts RUN cycles down to 1.
  // A flush never touches it; the running divide belongs to an older instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 6'd0;
    end else if (go) begin
      cnt <= CNT_INIT;
    end else if (state == ST_RUN) begin
      cnt <= cnt - 6'd1;
    end
  end

  // Sign and divide-by-zero flag are captured with the start and held
  // until the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (go) begin
      sign_q     <= bus.ex_signed;
      div_zero_q <= (bus.ex_divisor == 32'd0);
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_c),
    .cnt (bus.stall_cnt)
  );

  assign bus.div_op   = div_op_c;
  assign bus.div_busy = busy_c;
  assign bus.hilo_we  = we_c;
  assign bus.stall    = stall_c;
  assign bus.bubble   = stall_c;
  assign bus.div_zero = div_zero_q;

  // Sanity properties: the counter is never zero while running, and the
  // HiLo strobe is a single-cycle pulse.
  a_cnt_live : assert property (@(posedge clk) disable iff (!rst)
    (state == ST_RUN) |-> (cnt != 6'd0));
  a_we_pulse : assert property (@(posedge clk) disable iff (!rst)
    we_c |=> !we_c);

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed EX sequences, HiLo strobe scoreboard.
// Latency: expected hilo_we cycle queued at each divide start, checked on the strobe.
// Backpressure: stall/bubble windows checked against cycle-relative expectations.
module tb_muldiv_sched;

  localparam int DC = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_q[$];

  muldiv_sched_if #(.CNT_W(CW)) bus();

  muldiv_sched #(
    .DIV_CYCLES(DC),
    .CNT_W     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_in(input logic v, input logic d, input logic s, input logic h,
                        input logic [31:0] dv, input logic f);
    bus.ex_valid      = v;
    bus.ex_is_div     = d;
    bus.ex_signed     = s;
    bus.ex_is_hilo_rd = h;
    bus.ex_divisor    = dv;
    bus.flush         = f;
  endtask

  // Plain ALU instruction in EX: valid, neither divide nor HiLo read.
  task automatic alu_in();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // HiLo strobe scoreboard: each strobe must match the oldest expected cycle.
  always @(negedge clk) begin
    if (bus.hilo_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("hilo_we_unexpected", 32'd1, 32'd0);
      end else begin
        check("hilo_we_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    int base;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // ---- reset state ----
    #1 rst = 1'b0;
    #1;
    check("rst_div_op", bus.div_op, 0);
    check("rst_busy", bus.div_busy, 0);
    check("rst_hilo_we", bus.hilo_we, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_bubble", bus.bubble, 0);
    check("rst_div_zero", bus.div_zero, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    repeat (2) next();
    rst = 1'b1;
    next(); alu_in(); settle();

    // ---- lone DIV, divisor 7 ----
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd7, 1'b0);
    exp_q.push_back(t + DC + 1);
    settle();
    check("div1_start_stall", bus.stall, 0);
    check("div1_start_busy", bus.div_busy, 0);
    base = int'(bus.stall_cnt);
    for (int k = 1; k <= DC + 2; k++) begin
      next(); alu_in(); settle();
      check("div1_op", bus.div_op, (k <= DC + 1) ? 26 : 0);
      check("div1_we", bus.hilo_we, (k == DC + 1) ? 1 : 0);
      check("div1_stall", bus.stall, 0);
    end
    check("div1_stall_cnt", bus.stall_cnt, base);

    // ---- DIV then dependent MFHI ----
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd9, 1'b0);
    exp_q.push_back(t + DC + 1);
    settle();
    base = int'(bus.stall_cnt);
    for (int k = 1; k <= DC + 2; k++) begin
      next(); set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0); settle();
      check("mfhi_stall", bus.stall, (k <= DC + 1) ? 1 : 0);
      check("mfhi_bubble", bus.bubble, (k <= DC + 1) ? 1 : 0);
    end
    next(); alu_in(); settle();
    check("mfhi_stall_cnt", bus.stall_cnt, base + DC + 1);

    // ---- back-to-back DIVU ----
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 1'b0);
    exp_q.push_back(t + DC + 1);
    settle();
    base = int'(bus.stall_cnt);
    for (int k = 1; k <= 2 * DC + 4; k++) begin
      next();
      if (k <= DC + 2) set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'd11, 1'b0);
      else alu_in();
      if (k == DC + 2) exp_q.push_back(t + k + DC + 1);
      settle();
      check("b2b_stall", bus.stall, (k <= DC + 1) ? 1 : 0);
      check("b2b_op", bus.div_op,
            ((k <= DC + 1) || (k >= DC + 3 && k <= 2 * DC + 3)) ? 27 : 0);
      check("b2b_busy", bus.div_busy,
            ((k <= DC + 1) || (k >= DC + 3 && k <= 2 * DC + 3)) ? 1 : 0);
    end
    check("b2b_stall_cnt", bus.stall_cnt, base + DC + 1);

    // ---- flushed DIV in IDLE: no start ----
    next(); set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 1'b1); settle();
    check("flush_div_stall", bus.stall, 0);
    for (int k = 1; k <= 3; k++) begin
      next(); alu_in(); settle();
      check("flush_div_busy", bus.div_busy, 0);
      check("flush_div_op", bus.div_op, 0);
    end

    // ---- flush during RUN with MFLO in EX ----
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd6, 1'b0);
    exp_q.push_back(t + DC + 1);
    settle();
    base = int'(bus.stall_cnt);
    for (int k = 1; k <= DC + 2; k++) begin
      next();
      if (k == 5 || k == 7) set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1);
      else if (k == 6) set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
      else alu_in();
      settle();
      check("flush_run_stall", bus.stall, (k == 6) ? 1 : 0);
      check("flush_run_busy", bus.div_busy, (k <= DC + 1) ? 1 : 0);
    end
    check("flush_run_stall_cnt", bus.stall_cnt, base + 1);

    // ---- DIVU by zero, then DIVU by 3 clears the flag ----
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    exp_q.push_back(t + DC + 1);
    settle();
    check("dz_pre", bus.div_zero, 0);
    for (int k = 1; k <= DC + 1; k++) begin
      next(); alu_in(); settle();
      check("dz_run", bus.div_zero, 1);
    end
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0);
    exp_q.push_back(t + DC + 1);
    settle();
    check("dz_hold", bus.div_zero, 1);
    next(); alu_in(); settle();
    check("dz_clear", bus.div_zero, 0);
    check("dz_op", bus.div_op, 27);
    for (int k = 2; k <= DC + 2; k++) begin
      next(); alu_in(); settle();
    end

    // ---- reset mid-RUN ----
    next(); t = cyc;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    settle();
    for (int k = 1; k <= 9; k++) begin
      next(); set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0); settle();
      check("rst_pre_stall", bus.stall, 1);
    end
    next(); set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    #1;
    check("rst_pre_div_zero", bus.div_zero, 1);
    rst = 1'b0;
    #1;
    check("rstm_div_op", bus.div_op, 0);
    check("rstm_busy", bus.div_busy, 0);
    check("rstm_hilo_we", bus.hilo_we, 0);
    check("rstm_stall", bus.stall, 0);
    check("rstm_bubble", bus.bubble, 0);
    check("rstm_div_zero", bus.div_zero, 0);
    check("rstm_stall_cnt", bus.stall_cnt, 0);
    next(); rst = 1'b1; alu_in();
    for (int k = 1; k <= DC + 8; k++) begin
      next(); alu_in(); settle();
      check("rst_after_busy", bus.div_busy, 0);
    end

    next();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
